// File: rtl/sample_pkg.sv
// -----------------------------------------------------------------------------
// sample_pkg
// Shared definitions for the sample packetizer:
//   - state_t: packetizer FSM state encoding (2-bit)
//   - default_* constants: default FIFO depth, packet size and idle timeout
// No ports (package).
// -----------------------------------------------------------------------------
package sample_pkg;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_fetch = 2'd1,
    st_lo    = 2'd2,
    st_hi    = 2'd3
  } state_t;

  localparam int default_depth_log2     = 9;
  localparam int default_max_packet     = 64;
  localparam int default_timeout_cycles = 48000;

endpackage

// File: rtl/sample_fifo_ram.sv
// -----------------------------------------------------------------------------
// sample_fifo_ram
// Simple dual-port RAM, 16 bits wide, 2^depth_log2 entries, used as the
// storage of the packetizer's circular FIFO. Storage is not reset.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata updates on the next edge only when re is high
//   raddr  read address
//   rdata  registered read data (holds its value while re is low)
// -----------------------------------------------------------------------------
module sample_fifo_ram
  import sample_pkg::*;
#(
  parameter int depth_log2 = default_depth_log2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [depth_log2-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic                  re,
  input  logic [depth_log2-1:0] raddr,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(1 << depth_log2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // rdata is held between reads; the packetizer muxes both bytes of a
    // word out of it across the st_lo and st_hi states.
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_packetizer.sv
// -----------------------------------------------------------------------------
// sample_packetizer
// Buffers a strobed 16-bit word stream in a circular FIFO and re-emits it as a
// byte stream (low byte first) with valid/ready handshake and packet framing.
// A packet closes at max_packet bytes, or as a short packet on flush (explicit
// request or idle timeout).
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_data    compressed word
//   in_valid   one-cycle strobe; word accepted unless FIFO full
//   out_data   byte to endpoint (0 while out_valid is low)
//   out_valid  byte available
//   out_ready  endpoint accepts byte this cycle
//   out_last   final byte of a packet
//   flush      one-cycle request to close buffered data as a short packet
//   clear      synchronous pipeline clear
//   overflow   sticky: a word was dropped because the FIFO was full
//   level      words currently held in the FIFO
// -----------------------------------------------------------------------------
module sample_packetizer
  import sample_pkg::*;
#(
  parameter int depth_log2     = default_depth_log2,
  parameter int max_packet     = default_max_packet,
  parameter int timeout_cycles = default_timeout_cycles
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         in_data,
  input  logic                in_valid,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  input  logic                flush,
  input  logic                clear,
  output logic                overflow,
  output logic [depth_log2:0] level
);

  localparam int bc_w = $clog2(max_packet) + 1;
  localparam int tm_w = $clog2(timeout_cycles + 1);

  localparam logic [depth_log2:0] level_full = {1'b1, {depth_log2{1'b0}}};
  localparam logic [bc_w-1:0]     max_len    = bc_w'(max_packet);
  localparam logic [tm_w-1:0]     timer_max  = tm_w'(timeout_cycles - 1);
  localparam logic [31:0]         half_words = 32'(max_packet / 2);

  state_t                state;
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  flush_pending;
  logic                  flush_pending_next;
  logic [tm_w-1:0]       timer;
  logic [bc_w-1:0]       pkt_len;
  logic [bc_w-1:0]       byte_cnt;
  logic [bc_w-1:0]       byte_cnt_inc;
  logic [bc_w-1:0]       last_idx;
  logic [15:0]           rdata;
  logic [31:0]           level_wide;

  logic full;
  logic wr_en;
  logic pop;
  logic level_ge_half;
  logic idle_decide;
  logic timeout_hit;

  assign full          = (level == level_full);
  // A write coinciding with clear is dropped.
  assign wr_en         = in_valid && !full && !clear;
  assign pop           = (state == st_fetch) && !clear;
  assign level_wide    = 32'(level);
  assign level_ge_half = (level_wide >= half_words);
  assign byte_cnt_inc  = byte_cnt + bc_w'(1);
  assign last_idx      = pkt_len - bc_w'(1);

  // Idle cycles that are not starting a full packet are where a pending
  // flush is consumed or the idle timer runs.
  assign idle_decide = (state == st_idle) && !level_ge_half;
  assign timeout_hit = idle_decide && !flush_pending && (level != '0) &&
                       (timer == timer_max);

  // A new flush request always wins, so a request arriving on the very
  // cycle an older one is consumed is not lost.
  always_comb begin
    flush_pending_next = flush_pending;
    if (idle_decide && flush_pending) begin
      flush_pending_next = 1'b0;
    end
    if (timeout_hit) begin
      flush_pending_next = 1'b1;
    end
    if (flush) begin
      flush_pending_next = 1'b1;
    end
  end

  // Bytes come straight from the held RAM output; gated to 0 when idle so the
  // port has a defined value even though RAM storage is never reset.
  assign out_data = !out_valid        ? 8'h00 :
                    (state == st_hi)  ? rdata[15:8] : rdata[7:0];

  sample_fifo_ram #(
    .depth_log2 (depth_log2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= st_idle;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      flush_pending <= 1'b0;
      timer         <= '0;
      pkt_len       <= '0;
      byte_cnt      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else if (clear) begin
      state         <= st_idle;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      flush_pending <= 1'b0;
      timer         <= '0;
      byte_cnt      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + depth_log2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + depth_log2'(1);
      end
      if (wr_en && !pop) begin
        level <= level + 1'b1;
      end else if (!wr_en && pop) begin
        level <= level - 1'b1;
      end
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
      flush_pending <= flush_pending_next;

      case (state)
        st_idle: begin
          if (level_ge_half) begin
            pkt_len  <= max_len;
            byte_cnt <= '0;
            timer    <= '0;
            state    <= st_fetch;
          end else if (flush_pending && (level != '0)) begin
            // Short packet sized from the words present right now; words
            // arriving later wait for the next packet.
            pkt_len  <= bc_w'({level, 1'b0});
            byte_cnt <= '0;
            timer    <= '0;
            state    <= st_fetch;
          end else if (!flush_pending && (level != '0)) begin
            if (timer != timer_max) begin
              timer <= timer + tm_w'(1);
            end
          end else begin
            timer <= '0;
          end
        end
        st_fetch: begin
          timer     <= '0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;  // packets are even-length: a low byte never ends one
          state     <= st_lo;
        end
        st_lo: begin
          timer <= '0;
          if (out_ready) begin
            byte_cnt <= byte_cnt_inc;
            out_last <= (byte_cnt_inc == last_idx);
            state    <= st_hi;
          end
        end
        st_hi: begin
          timer <= '0;
          if (out_ready) begin
            byte_cnt  <= byte_cnt_inc;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= (byte_cnt == last_idx) ? st_idle : st_fetch;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_packetizer.sv
// -----------------------------------------------------------------------------
// tb_sample_packetizer
// Two packetizer instances share one stimulus stream:
//   dut_a: depth 64 words, 64-byte packets, 100-cycle idle timeout
//   dut_b: depth 16 words, 256-byte packets, very long timeout (overflow case)
// Expected bytes come from a word queue (low byte, then high byte); packet
// lengths are collected from out_last and compared with the expected framing.
// -----------------------------------------------------------------------------
module tb_sample_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        flush = 1'b0;
  logic        clear = 1'b0;

  logic [7:0]  out_data_a;
  logic        out_valid_a, out_last_a, overflow_a;
  logic [6:0]  level_a;
  logic [7:0]  out_data_b;
  logic        out_valid_b, out_last_b, overflow_b;
  logic [4:0]  level_b;

  int n_tests = 0;
  int n_fail  = 0;

  bit mon_a      = 1'b1;
  bit mon_b      = 1'b0;
  bit rand_ready = 1'b0;

  logic [7:0] exp_q[$];
  int         pkt_lens[$];
  int         cur_len = 0;
  int         bytes_a = 0;
  logic [7:0] got_b[$];
  int         last_pos_b[$];

  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  sample_packetizer #(.depth_log2(6), .max_packet(64), .timeout_cycles(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_last(out_last_a), .flush(flush), .clear(clear),
    .overflow(overflow_a), .level(level_a)
  );

  sample_packetizer #(.depth_log2(4), .max_packet(256), .timeout_cycles(100000)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_last(out_last_b), .flush(flush), .clear(clear),
    .overflow(overflow_b), .level(level_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // dut_a monitor: handshake stability, byte scoreboard, packet lengths.
  always @(negedge clk) begin
    if (rst_n && mon_a && !clear) begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid_a), 32'd1);
        check("hold_data",  32'(out_data_a),  32'(prev_data));
        check("hold_last",  32'(out_last_a),  32'(prev_last));
      end
      prev_hold = out_valid_a && !out_ready;
      prev_data = out_data_a;
      prev_last = out_last_a;
      if (out_valid_a && out_ready) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("byte", 32'(out_data_a), 32'(exp_q.pop_front()));
        end
        cur_len++;
        bytes_a++;
        if (out_last_a) begin
          $display("[TB] dut_a packet closed, %0d bytes", cur_len);
          pkt_lens.push_back(cur_len);
          cur_len = 0;
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_b && !clear && out_valid_b && out_ready) begin
      got_b.push_back(out_data_b);
      if (out_last_b) last_pos_b.push_back(got_b.size());
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 3);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    in_data  = w;
    in_valid = 1'b1;
    if (mon_a) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
    $display("[TB] write 0x%04h", w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_model();
    exp_q.delete();
    pkt_lens.delete();
    got_b.delete();
    last_pos_b.delete();
    cur_len = 0;
    bytes_a = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    reset_model();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_a) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int first_k;
    int sent;
    int nvalid;
    bit seen;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a",    32'(out_valid_a), 32'd0);
    check("rst_last_a",     32'(out_last_a),  32'd0);
    check("rst_data_a",     32'(out_data_a),  32'd0);
    check("rst_overflow_a", 32'(overflow_a),  32'd0);
    check("rst_level_a",    32'(level_a),     32'd0);
    check("rst_level_b",    32'(level_b),     32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- full packet ----------------
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) write_word(16'h0100 + 16'(i));
    wait_drain("full_drain", 400);
    repeat (2) tick();
    check("full_npkts", 32'(pkt_lens.size()), 32'd1);
    if (pkt_lens.size() > 0) check("full_len", 32'(pkt_lens[0]), 32'd64);
    check("full_level", 32'(level_a), 32'd0);

    // ---------------- timeout ----------------
    do_clear();
    write_word(16'hAAAA);
    write_word(16'hBBBB);
    write_word(16'hCCCC);
    first_k = -1;
    for (int k = 3; k <= 140 && first_k < 0; k++) begin
      tick();
      if (out_valid_a) first_k = k;
    end
    $display("[TB] timeout packet first valid at cycle %0d", first_k);
    check("timeout_not_early", 32'(first_k >= 100), 32'd1);
    check("timeout_in_time",   32'(first_k >= 0 && first_k <= 110), 32'd1);
    wait_drain("timeout_drain", 200);
    check("timeout_npkts", 32'(pkt_lens.size()), 32'd1);
    if (pkt_lens.size() > 0) check("timeout_len", 32'(pkt_lens[0]), 32'd6);

    // ---------------- overflow (dut_b) ----------------
    do_clear();
    mon_a     = 1'b0;
    mon_b     = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) write_word(16'(i + 1));
    tick();
    check("ovf_level",    32'(level_b),    32'd16);
    check("ovf_flag",     32'(overflow_b), 32'd1);
    repeat (5) tick();
    check("ovf_sticky",   32'(overflow_b), 32'd1);
    pulse_flush();
    out_ready = 1'b1;
    for (int n = 0; n < 300 && got_b.size() < 32; n++) tick();
    repeat (5) tick();
    check("ovf_nbytes", 32'(got_b.size()), 32'd32);
    for (int i = 0; i < 16 && 2 * i + 1 < got_b.size(); i++) begin
      check("ovf_lo", 32'(got_b[2 * i]),     32'(i + 1));
      check("ovf_hi", 32'(got_b[2 * i + 1]), 32'd0);
    end
    check("ovf_npkts", 32'(last_pos_b.size()), 32'd1);
    if (last_pos_b.size() > 0) check("ovf_last_pos", 32'(last_pos_b[0]), 32'd32);
    check("ovf_still_set", 32'(overflow_b), 32'd1);
    mon_b = 1'b0;
    do_clear();
    mon_a = 1'b1;

    // ---------------- random backpressure ----------------
    rand_ready = 1'b1;
    sent = 0;
    while (sent < 50) begin
      if ($urandom_range(0, 3) == 0) begin
        write_word(16'($urandom));
        sent++;
      end else begin
        if ($urandom_range(0, 19) == 0) flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end
    wait_drain("bp_drain", 4000);
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    check("bp_level", 32'(level_a), 32'd0);
    foreach (pkt_lens[i]) begin
      check("bp_pkt_len_ok", 32'(pkt_lens[i] <= 64 && pkt_lens[i] % 2 == 0), 32'd1);
    end

    // ---------------- flush with empty FIFO ----------------
    do_clear();
    pulse_flush();
    nvalid = 0;
    for (int n = 0; n < 150; n++) begin
      tick();
      if (out_valid_a) nvalid++;
    end
    check("flush_empty_novalid", 32'(nvalid), 32'd0);

    // ---------------- flush mid full packet ----------------
    do_clear();
    for (int i = 0; i < 32; i++) write_word(16'h2000 + 16'(i));
    for (int i = 0; i < 5; i++)  write_word(16'h2100 + 16'(i));
    pulse_flush();
    wait_drain("midflush_drain", 1000);
    check("midflush_npkts", 32'(pkt_lens.size()), 32'd2);
    if (pkt_lens.size() > 0) check("midflush_len0", 32'(pkt_lens[0]), 32'd64);
    if (pkt_lens.size() > 1) check("midflush_len1", 32'(pkt_lens[1]), 32'd10);

    // ---------------- clear mid-packet ----------------
    do_clear();
    for (int i = 0; i < 32; i++) write_word(16'h4000 + 16'(i));
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      if (bytes_a >= 10) seen = 1'b1;
      else tick();
    end
    check("clr_reached_10", 32'(bytes_a), 32'd10);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid",      32'(out_valid_a), 32'd0);
    check("clr_level",      32'(level_a),     32'd0);
    check("clr_overflow_a", 32'(overflow_a),  32'd0);
    check("clr_overflow_b", 32'(overflow_b),  32'd0);
    reset_model();
    for (int i = 0; i < 32; i++) write_word(16'h5000 + 16'(i));
    wait_drain("clr_drain", 400);
    check("clr_npkts", 32'(pkt_lens.size()), 32'd1);
    if (pkt_lens.size() > 0) check("clr_len", 32'(pkt_lens[0]), 32'd64);
    check("clr_level_end", 32'(level_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_packetizer.md
Name: sample_packetizer

Overview:
- Downstream of the sampler/compressor chain. Consumes the compressed 16-bit word stream, which has single-cycle strobes and no backpressure.
- Buffers the words in an on-chip circular FIFO. Re-emits them as a byte stream with valid/ready handshake and packet framing (out_last), for a USB bulk IN endpoint.
- Packets close either at max size or on flush: explicit request or idle timeout.

Parameters:
depth_log2, 9, FIFO depth = 2^depth_log2 16-bit words
max_packet, 64, bytes per full packet (even, >= 4)
timeout_cycles, 48000, clk cycles FIFO may sit non-empty and idle before an automatic flush

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_data  in  16  compressed word
in_valid  in  1  one-cycle strobe; word accepted unconditionally unless FIFO full
out_data  out  8  byte to endpoint
out_valid  out  1  byte available
out_ready  in  1  endpoint accepts byte this cycle
out_last  out  1  qualifies final byte of a packet
flush  in  1  one-cycle request: close out buffered data as a short packet
clear  in  1  one-cycle synchronous pipeline clear
overflow  out  1  sticky: a word was dropped because FIFO was full
level  out  depth_log2+1  words currently in FIFO

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_last=0, out_data=0, overflow=0, level=0, state=st_idle, flush_pending=0, timer=0, pointers=0.
- Write: in_valid && !full -> store at wr_ptr, wr_ptr+1 (wraps mod 2^depth_log2). full = (level == 2^depth_log2).
- in_valid && full -> word dropped, overflow<=1. overflow is cleared only by reset or clear.
- Pop happens on read issue in st_fetch. A write and a pop in the same cycle leave level unchanged; level is exact every cycle.
- RAM read latency is 1 cycle (registered output).
- Byte order: low byte first, then high byte.
- States:
  - st_idle:
    - level >= max_packet/2 -> pkt_len=max_packet, go st_fetch.
    - else if flush_pending && level>0 -> pkt_len=2*level (snapshot), flush_pending<=0, go st_fetch.
    - else if flush_pending && level==0 -> flush_pending<=0. No zero-length packet is generated.
  - st_fetch: issue read, pop, go st_lo.
  - st_lo: out_valid=1, out_data=word[7:0]. Hold until out_ready, then go st_hi.
  - st_hi: out_valid=1, out_data=word[15:8]. On out_ready: byte_cnt==pkt_len-1 -> st_idle, else st_fetch.
- out_last = out_valid && (byte_cnt == pkt_len-1). byte_cnt resets to 0 on entering a packet and increments per accepted byte.
- Handshake: while out_valid && !out_ready, out_data and out_last hold stable. out_valid never drops without acceptance, except on clear.
- Throughput: 2 bytes per 3 cycles at most (fetch bubble). This is acceptable because the USB rate is far below clk.
- Timer:
  - Counts in st_idle while level>0 && !flush_pending. Zeroed otherwise and whenever a packet starts.
  - On reaching timeout_cycles-1 -> flush_pending<=1.
- flush input sets flush_pending in any state. It is consumed only in st_idle, so a flush raised mid-packet closes the next packet.
- clear (synchronous, highest priority after reset):
  - Pointers=0, level=0, overflow=0, flush_pending=0, timer=0, state=st_idle, out_valid=0.
  - Any packet in flight is truncated; the host side discards truncated packets.
  - A write coinciding with clear is dropped.
- Widths: level, pointers and byte_cnt are unsigned. byte_cnt width is $clog2(max_packet)+1. Timer width is $clog2(timeout_cycles+1).

Decomposition:
- Package sample_pkg: state encodings st_idle/st_fetch/st_lo/st_hi (2-bit) and default constants for depth_log2, max_packet, timeout_cycles.
- One sub-module, sample_fifo_ram: simple dual-port RAM, width 16, depth 2^depth_log2.
  - Write port: we, waddr, wdata.
  - Read port: re, raddr, rdata registered.
  - No reset on storage.

Test Plan:
- Full packet: max_packet=64, out_ready=1. Write 32 words 0x0100..0x011F -> 64 bytes 00,01,01,01,...,1F,01; out_last only on byte 64; level returns to 0.
- Timeout: timeout_cycles=100. Write 0xAAAA,0xBBBB,0xCCCC, then idle -> after 100 idle cycles, packet AA,AA,BB,BB,CC,CC with out_last on 6th byte; nothing before cycle 100.
- Overflow: depth_log2=4, out_ready=0, max_packet large. Write 20 words -> level=16, overflow=1 and stays 1. Then flush and drain -> exactly words 1..16 emitted.
- Backpressure: out_ready random 30%. Check out_data/out_last stable while out_valid && !out_ready; byte stream equals input stream; no duplicates.
- Flush edges:
  - flush with FIFO empty -> no out_valid ever.
  - flush mid full packet -> full packet completes, then short packet of remaining words.
- Clear mid-packet: clear after byte 10 -> out_valid=0 next cycle, level=0, overflow=0. Subsequent 32-word write produces a clean 64-byte packet.
